// File: rtl/rout_xy_switch.sv
`default_nettype none
// ============================================================================
// Module   : rout_xy_switch
// Purpose  : 5-port mesh router node (LOCAL, NORTH, EAST, SOUTH, WEST).
//            Each input has a circular-buffer FIFO.
//            Single-flit messages are routed X-then-Y from the head flit's
//            destination coordinates.
//            Each output has a round-robin arbiter and a registered output
//            stage.
// Ports    : clk, rst_n       - clock, synchronous active-low reset
//            in_tvalid/ready  - per-input handshake (NUM_PORTS bits)
//            in_tdata         - input flits, port p at [p*PORT_WIDTH +: PORT_WIDTH]
//            out_tvalid/ready - per-output handshake (NUM_PORTS bits)
//            out_tdata        - output flits, same packing as in_tdata
// Flit     : {src_x, src_y, dst_x, dst_y, mtype[7:0], data}, MSB first
// Revision : 1.0 - initial release
// ============================================================================
module rout_xy_switch #(
    parameter int PORT_WIDTH = 128,
    parameter int COORD_W    = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int LOCAL_X    = 0,
    parameter int LOCAL_Y    = 0,
    parameter int NUM_PORTS  = 5
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            in_tvalid,
    output logic [NUM_PORTS-1:0]            in_tready,
    input  logic [NUM_PORTS*PORT_WIDTH-1:0] in_tdata,
    output logic [NUM_PORTS-1:0]            out_tvalid,
    input  logic [NUM_PORTS-1:0]            out_tready,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] out_tdata
);

    localparam int               c_aw         = $clog2(FIFO_DEPTH);
    localparam int               c_dst_x_lsb  = PORT_WIDTH - 3*COORD_W;
    localparam int               c_dst_y_lsb  = PORT_WIDTH - 4*COORD_W;
    localparam logic [COORD_W-1:0] c_local_x  = COORD_W'(LOCAL_X);
    localparam logic [COORD_W-1:0] c_local_y  = COORD_W'(LOCAL_Y);
    localparam logic [c_aw:0]    c_ptr_one    = (c_aw+1)'(1);
    localparam logic [2:0]       c_port_local = 3'd0;
    localparam logic [2:0]       c_port_north = 3'd1;
    localparam logic [2:0]       c_port_east  = 3'd2;
    localparam logic [2:0]       c_port_south = 3'd3;
    localparam logic [2:0]       c_port_west  = 3'd4;

    // Input FIFOs
    logic [PORT_WIDTH-1:0] r_mem    [NUM_PORTS][FIFO_DEPTH];
    logic [c_aw:0]         r_wr_ptr [NUM_PORTS];
    logic [c_aw:0]         r_rd_ptr [NUM_PORTS];
    logic [NUM_PORTS-1:0]  w_full;
    logic [NUM_PORTS-1:0]  w_empty;
    logic [NUM_PORTS-1:0]  w_push;
    logic [NUM_PORTS-1:0]  w_pop;
    logic [PORT_WIDTH-1:0] w_head   [NUM_PORTS];
    logic [COORD_W-1:0]    w_dst_x  [NUM_PORTS];
    logic [COORD_W-1:0]    w_dst_y  [NUM_PORTS];
    logic [2:0]            w_route  [NUM_PORTS];

    // Arbitration, indexed [output][input]
    logic [NUM_PORTS-1:0]  w_req       [NUM_PORTS];
    logic [NUM_PORTS-1:0]  w_grant     [NUM_PORTS];
    logic [2:0]            w_grant_idx [NUM_PORTS];
    logic [NUM_PORTS-1:0]  w_grant_vld;
    logic [NUM_PORTS-1:0]  w_load;
    logic [3:0]            w_sum;

    // Output stage
    logic [2:0]            r_rr_ptr    [NUM_PORTS];
    logic [NUM_PORTS-1:0]  r_out_valid;
    logic [PORT_WIDTH-1:0] r_out_data  [NUM_PORTS];

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
            // Extra pointer MSB tells a full buffer from an empty one.
            assign w_full[p]    = (r_wr_ptr[p][c_aw] != r_rd_ptr[p][c_aw]) &&
                                  (r_wr_ptr[p][c_aw-1:0] == r_rd_ptr[p][c_aw-1:0]);
            assign w_empty[p]   = (r_wr_ptr[p] == r_rd_ptr[p]);
            // Ready depends only on registered FIFO state, never on out_tready.
            assign in_tready[p] = rst_n && !w_full[p];
            assign w_push[p]    = in_tvalid[p] && in_tready[p];
            assign w_head[p]    = r_mem[p][r_rd_ptr[p][c_aw-1:0]];
            assign w_dst_x[p]   = w_head[p][c_dst_x_lsb +: COORD_W];
            assign w_dst_y[p]   = w_head[p][c_dst_y_lsb +: COORD_W];
        end

        for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
            assign w_load[o]     = !r_out_valid[o] || out_tready[o];
            assign out_tvalid[o] = r_out_valid[o];
            assign out_tdata[o*PORT_WIDTH +: PORT_WIDTH] = r_out_data[o];
        end
    endgenerate

    // Dimension-ordered routing: resolve X completely before Y.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_dst_x[p] > c_local_x)
                w_route[p] = c_port_east;
            else if (w_dst_x[p] < c_local_x)
                w_route[p] = c_port_west;
            else if (w_dst_y[p] > c_local_y)
                w_route[p] = c_port_north;
            else if (w_dst_y[p] < c_local_y)
                w_route[p] = c_port_south;
            else
                w_route[p] = c_port_local;
        end
    end

    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            w_req[o] = '0;
            for (int p = 0; p < NUM_PORTS; p++)
                w_req[o][p] = !w_empty[p] && (w_route[p] == 3'(o));
        end
    end

    // Round-robin: search ptr+1, ptr+2, ... modulo NUM_PORTS.
    // The scan runs from the farthest candidate down to the nearest, so the
    // last hit is the highest-priority requester.
    always_comb begin
        w_sum = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            w_grant_idx[o] = r_rr_ptr[o];
            for (int k = NUM_PORTS; k >= 1; k--) begin
                w_sum = {1'b0, r_rr_ptr[o]} + 4'(k);
                if (w_sum >= 4'(NUM_PORTS))
                    w_sum = w_sum - 4'(NUM_PORTS);
                if (w_req[o][w_sum[2:0]])
                    w_grant_idx[o] = w_sum[2:0];
            end
            w_grant_vld[o] = w_load[o] && (|w_req[o]);
            w_grant[o]     = w_grant_vld[o] ? (NUM_PORTS'(1) << w_grant_idx[o]) : '0;
        end
    end

    // Each input requests a single output, so at most one grant per input.
    always_comb begin
        w_pop = '0;
        for (int o = 0; o < NUM_PORTS; o++)
            w_pop = w_pop | w_grant[o];
    end

    // FIFO storage needs no reset; emptiness is carried by the pointers.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_push[p])
                r_mem[p][r_wr_ptr[p][c_aw-1:0]] <= in_tdata[p*PORT_WIDTH +: PORT_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (!rst_n) begin
                r_wr_ptr[p] <= '0;
                r_rd_ptr[p] <= '0;
            end else begin
                if (w_push[p])
                    r_wr_ptr[p] <= r_wr_ptr[p] + c_ptr_one;
                if (w_pop[p])
                    r_rd_ptr[p] <= r_rd_ptr[p] + c_ptr_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (!rst_n) begin
                r_out_valid[o] <= 1'b0;
                r_out_data[o]  <= '0;
                r_rr_ptr[o]    <= 3'(NUM_PORTS-1);
            end else if (w_load[o]) begin
                if (w_grant_vld[o]) begin
                    r_out_valid[o] <= 1'b1;
                    r_out_data[o]  <= w_head[w_grant_idx[o]];
                    r_rr_ptr[o]    <= w_grant_idx[o];
                end else begin
                    r_out_valid[o] <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rout_xy_switch.sv
`default_nettype none
// ============================================================================
// Module   : tb_rout_xy_switch
// Purpose  : Directed self-checking bench for rout_xy_switch. The node sits
//            at (1,1) and uses 64-bit flits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rout_xy_switch;

    localparam int c_pw = 64;
    localparam int c_np = 5;

    logic                 clk;
    logic                 rst_n;
    logic [c_np-1:0]      in_tvalid;
    logic [c_np-1:0]      in_tready;
    logic [c_np*c_pw-1:0] in_tdata;
    logic [c_np-1:0]      out_tvalid;
    logic [c_np-1:0]      out_tready;
    logic [c_np*c_pw-1:0] out_tdata;
    logic [c_pw-1:0]      din [c_np];

    int n_checks;
    int n_errors;

    assign in_tdata = {din[4], din[3], din[2], din[1], din[0]};

    rout_xy_switch #(
        .PORT_WIDTH (c_pw),
        .COORD_W    (4),
        .FIFO_DEPTH (16),
        .LOCAL_X    (1),
        .LOCAL_Y    (1),
        .NUM_PORTS  (c_np)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .in_tdata   (in_tdata),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_tdata  (out_tdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Flit: src_x[63:60] src_y[59:56] dst_x[55:52] dst_y[51:48] mtype[47:40] data[39:0]
    function automatic logic [63:0] mk(input logic [3:0] sx, input logic [3:0] sy,
                                       input logic [3:0] dx, input logic [3:0] dy,
                                       input logic [7:0] mt, input logic [39:0] d);
        return {sx, sy, dx, dy, mt, d};
    endfunction

    function automatic logic [63:0] out_of(input int o);
        return out_tdata[o*c_pw +: c_pw];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // One flit on an idle switch: absent after the push edge, present on
    // exp_port after the following edge, gone one edge later.
    task automatic send_one(input string tag, input int port, input logic [63:0] f,
                            input int exp_port);
        din[port]       = f;
        in_tvalid[port] = 1'b1;
        tick();
        in_tvalid[port] = 1'b0;
        check_val({tag, "_early"}, 64'(out_tvalid), 64'h0);
        tick();
        check_val({tag, "_vld"}, 64'(out_tvalid), 64'(5'b1 << exp_port));
        check_val({tag, "_data"}, out_of(exp_port), f);
        tick();
        check_val({tag, "_clr"}, 64'(out_tvalid), 64'h0);
    endtask

    logic [63:0] exp_f;
    int          acc;

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        in_tvalid  = '0;
        out_tready = '1;
        for (int i = 0; i < c_np; i++) din[i] = '0;

        // Reset state
        tick();
        tick();
        check_val("rst_in_tready", 64'(in_tready), 64'h0);
        check_val("rst_out_tvalid", 64'(out_tvalid), 64'h0);
        check_val("rst_out_tdata", 64'(|out_tdata), 64'h0);
        rst_n = 1'b1;
        #1;
        check_val("rel_in_tready", 64'(in_tready), 64'h1f);

        // Latency and routing from LOCAL, then X before Y from NORTH
        send_one("east",  0, mk(4'd1, 4'd1, 4'd2, 4'd1, 8'h11, 40'hA1), 2);
        send_one("south", 0, mk(4'd1, 4'd1, 4'd1, 4'd0, 8'h12, 40'hA2), 3);
        send_one("local", 0, mk(4'd1, 4'd1, 4'd1, 4'd1, 8'h13, 40'hA3), 0);
        send_one("xfirst", 1, mk(4'd1, 4'd2, 4'd0, 4'd3, 8'h14, 40'hA4), 4);

        // Contention: LOCAL and SOUTH both stream to EAST, fresh pointers
        pulse_reset();
        for (int c = 0; c < 10; c++) begin
            in_tvalid[0] = (c < 4);
            in_tvalid[3] = (c < 4);
            din[0] = mk(4'd1, 4'd1, 4'd2, 4'd1, 8'h20, 40'(16'h100 + c));
            din[3] = mk(4'd1, 4'd0, 4'd2, 4'd1, 8'h21, 40'(16'h300 + c));
            tick();
            if (c >= 1 && c <= 8) begin
                if (((c - 1) % 2) == 0)
                    exp_f = mk(4'd1, 4'd1, 4'd2, 4'd1, 8'h20, 40'(16'h100 + (c - 1) / 2));
                else
                    exp_f = mk(4'd1, 4'd0, 4'd2, 4'd1, 8'h21, 40'(16'h300 + (c - 1) / 2));
                check_val($sformatf("rr_vld%0d", c), 64'(out_tvalid[2]), 64'h1);
                check_val($sformatf("rr_data%0d", c), out_of(2), exp_f);
            end else if (c == 9) begin
                check_val("rr_drain", 64'(out_tvalid), 64'h0);
            end
        end

        // Backpressure: EAST stalled, 20 flits offered on LOCAL
        out_tready[2] = 1'b0;
        acc = 0;
        for (int c = 0; c < 25; c++) begin
            din[0]       = mk(4'd1, 4'd1, 4'd2, 4'd1, 8'h30, 40'(acc));
            in_tvalid[0] = (acc < 20);
            if (in_tvalid[0] && in_tready[0]) acc++;
            tick();
        end
        in_tvalid[0] = 1'b0;
        check_val("bp_accepted", 64'(acc), 64'd17);
        check_val("bp_full_ready", 64'(in_tready[0]), 64'h0);
        check_val("bp_hold_vld", 64'(out_tvalid[2]), 64'h1);
        check_val("bp_hold_data", out_of(2), mk(4'd1, 4'd1, 4'd2, 4'd1, 8'h30, 40'd0));
        out_tready[2] = 1'b1;
        for (int j = 0; j < 17; j++) begin
            check_val($sformatf("bp_data%0d", j), out_of(2),
                      out_tvalid[2] ? mk(4'd1, 4'd1, 4'd2, 4'd1, 8'h30, 40'(j)) : 64'hDEAD);
            tick();
            if (j == 0) check_val("bp_ready_back", 64'(in_tready[0]), 64'h1);
        end
        check_val("bp_drain", 64'(out_tvalid), 64'h0);

        // Parallel flows: LOCAL->EAST, WEST->NORTH, NORTH->SOUTH
        for (int c = 0; c < 8; c++) begin
            in_tvalid[0] = (c < 6);
            in_tvalid[4] = (c < 6);
            in_tvalid[1] = (c < 6);
            din[0] = mk(4'd1, 4'd1, 4'd2, 4'd1, 8'h40, 40'(c));
            din[4] = mk(4'd0, 4'd1, 4'd1, 4'd2, 8'h41, 40'(c));
            din[1] = mk(4'd1, 4'd2, 4'd1, 4'd0, 8'h42, 40'(c));
            tick();
            if (c >= 1 && c <= 6) begin
                check_val($sformatf("par_vld%0d", c), 64'(out_tvalid), 64'h0e);
                check_val($sformatf("par_e%0d", c), out_of(2),
                          mk(4'd1, 4'd1, 4'd2, 4'd1, 8'h40, 40'(c - 1)));
                check_val($sformatf("par_n%0d", c), out_of(1),
                          mk(4'd0, 4'd1, 4'd1, 4'd2, 8'h41, 40'(c - 1)));
                check_val($sformatf("par_s%0d", c), out_of(3),
                          mk(4'd1, 4'd2, 4'd1, 4'd0, 8'h42, 40'(c - 1)));
            end
        end

        // Reset mid-operation with 8 flits held (1 output register + 7 FIFO).
        // The EAST pointer ends this phase pointing at port 0.
        out_tready[2] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            in_tvalid[0] = 1'b1;
            din[0] = mk(4'd1, 4'd1, 4'd2, 4'd1, 8'h50, 40'(c));
            tick();
        end
        in_tvalid[0] = 1'b0;
        check_val("mid_pre_vld", 64'(out_tvalid[2]), 64'h1);
        rst_n = 1'b0;
        tick();
        check_val("mid_rst_vld", 64'(out_tvalid), 64'h0);
        rst_n = 1'b1;
        #1;
        check_val("mid_rel_ready", 64'(in_tready), 64'h1f);
        out_tready = '1;
        tick();
        check_val("mid_empty", 64'(out_tvalid), 64'h0);

        // First arbitration after reset favours port 0, then 3, then 4
        din[0] = mk(4'd1, 4'd1, 4'd2, 4'd1, 8'h60, 40'h0);
        din[3] = mk(4'd1, 4'd0, 4'd2, 4'd1, 8'h63, 40'h3);
        din[4] = mk(4'd0, 4'd1, 4'd2, 4'd1, 8'h64, 40'h4);
        in_tvalid = 5'b11001;
        tick();
        in_tvalid = '0;
        tick();
        check_val("post_p0", out_of(2), mk(4'd1, 4'd1, 4'd2, 4'd1, 8'h60, 40'h0));
        tick();
        check_val("post_p3", out_of(2), mk(4'd1, 4'd0, 4'd2, 4'd1, 8'h63, 40'h3));
        tick();
        check_val("post_p4", out_of(2), mk(4'd0, 4'd1, 4'd2, 4'd1, 8'h64, 40'h4));
        tick();
        check_val("post_drain", 64'(out_tvalid), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
